// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared flit format, flit type codes and output-unit state encoding
// Revision : 1.0
// ============================================================================
package router_pkg;

  localparam int FLIT_SIZE     = 16;
  localparam int FLIT_TYPE_W   = 2;
  // Type field sits directly below the valid bit.
  localparam int FLIT_TYPE_MSB = FLIT_SIZE - 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_NONE = 2'd0,
    HEAD_FLIT = 2'd1,
    BODY_FLIT = 2'd2,
    TAIL_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef logic [FLIT_SIZE-1:0] FLIT_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    BACKOFF = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } OU_STATE_t;

  function automatic FLIT_t make_flit(input FLIT_TYPE_t t, input logic [FLIT_SIZE-4:0] payload);
    return {1'b1, t, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ou_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ou_fifo
// Purpose  : Synchronous FIFO with registered storage and full/empty flags
// Revision : 1.0
// ============================================================================
module ou_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  r_mem [c_DEPTH];
  logic [DEPTH_BITS:0] r_wr_ptr;
  logic [DEPTH_BITS:0] r_rd_ptr;
  logic w_push;
  logic w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                   (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);
  assign w_push  = i_wr_en && !o_full;
  assign w_pop   = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/output_unit.sv
`default_nettype none
// ============================================================================
// Module   : output_unit
// Purpose  : Router port transmitter: buffers switch flits, requests the link
//            per packet and streams head-to-tail to the downstream input unit
// Revision : 1.0
// ============================================================================
module output_unit #(
  parameter int FLIT_SIZE   = router_pkg::FLIT_SIZE,
  parameter int DEPTH_BITS  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FLIT_SIZE-1:0] i_sw_flit,
  input  logic                 i_sw_valid,
  output logic                 o_sw_ready,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic                 o_downstream_req,
  input  logic                 i_transmit_ack,
  output logic                 o_port_busy,
  output logic                 o_pkt_sent,
  output logic                 o_err
);

  import router_pkg::*;

  localparam int c_CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam int c_TYPE_MSB = FLIT_SIZE - 2;

  OU_STATE_t              r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [FLIT_SIZE-1:0]   r_flit;
  logic                   r_req;
  logic                   r_pkt_sent;
  logic                   r_err;

  logic [FLIT_SIZE-1:0]   w_fifo_dout;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [FLIT_TYPE_W-1:0] w_front_type;
  logic                   w_ack_taken;
  logic                   w_pop;
  logic [FLIT_SIZE-1:0]   w_load_flit;
  OU_STATE_t              w_load_state;
  logic                   w_load_err;

  ou_fifo #(
    .WIDTH      (FLIT_SIZE),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_data (i_sw_flit),
    .i_wr_en   (i_sw_valid),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_dout),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign w_front_type = w_fifo_dout[c_TYPE_MSB -: FLIT_TYPE_W];
  assign w_ack_taken  = i_transmit_ack && ((r_state == REQ) || (r_state == BACKOFF));
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == IDLE) || (r_state == SEND) || w_ack_taken);

  // Next link flit whenever the packet body is streaming (SEND or on grant).
  always_comb begin
    w_load_flit  = '0;
    w_load_state = SEND;
    w_load_err   = 1'b0;
    if (!w_fifo_empty) begin
      w_load_flit = {1'b1, w_fifo_dout[FLIT_SIZE-2:0]};
      if (w_front_type == TAIL_FLIT) w_load_state = DONE;
      if (w_front_type == HEAD_FLIT) w_load_err   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_flit     <= '0;
      r_req      <= 1'b0;
      r_pkt_sent <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pkt_sent <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            if (w_front_type == HEAD_FLIT) begin
              r_flit  <= {1'b1, w_fifo_dout[FLIT_SIZE-2:0]};
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= REQ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        REQ, BACKOFF: begin
          if (i_transmit_ack) begin
            r_req   <= 1'b0;
            r_flit  <= w_load_flit;
            r_state <= w_load_state;
            r_err   <= w_load_err;
          end else if (r_state == BACKOFF) begin
            r_req   <= 1'b1;
            r_state <= REQ;
          end else if ((ACK_TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= BACKOFF;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        SEND: begin
          r_flit  <= w_load_flit;
          r_state <= w_load_state;
          r_err   <= w_load_err;
        end
        DONE: begin
          r_flit     <= '0;
          r_pkt_sent <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sw_ready       = !w_fifo_full;
  assign o_flit           = r_flit;
  assign o_downstream_req = r_req;
  assign o_port_busy      = (r_state != IDLE);
  assign o_pkt_sent       = r_pkt_sent;
  assign o_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_output_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_unit
// Purpose  : Self-checking bench for output_unit with a downstream scoreboard
// Revision : 1.0
// ============================================================================
module tb_output_unit;

  import router_pkg::*;

  localparam int c_TO  = 4;
  localparam int c_MSB = FLIT_SIZE - 1;

  logic  clk = 1'b0;
  logic  reset;
  FLIT_t sw_flit;
  logic  sw_valid;
  logic  sw_ready;
  FLIT_t flit;
  logic  req;
  logic  ack;
  logic  busy;
  logic  pkt_sent;
  logic  err;

  int    n_checks = 0;
  int    n_errs   = 0;
  FLIT_t sb_q[$];
  logic  dn_active = 1'b0;

  always #5 clk = ~clk;

  output_unit #(
    .FLIT_SIZE   (FLIT_SIZE),
    .DEPTH_BITS  (2),
    .ACK_TIMEOUT (c_TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_sw_flit        (sw_flit),
    .i_sw_valid       (sw_valid),
    .o_sw_ready       (sw_ready),
    .o_flit           (flit),
    .o_downstream_req (req),
    .i_transmit_ack   (ack),
    .o_port_busy      (busy),
    .o_pkt_sent       (pkt_sent),
    .o_err            (err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_store(input FLIT_t f);
    FLIT_t e;
    if (sb_q.size() == 0) begin
      check("sb_extra_flit", 32'(f), 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("sb_flit", 32'(f), 32'(e));
    end
  endtask

  // Downstream input unit: head stored on the ack edge, then every MSB=1 flit up to the tail.
  always @(negedge clk) begin
    if (reset) begin
      dn_active <= 1'b0;
    end else if (dn_active) begin
      if (flit[c_MSB]) begin
        sb_store(flit);
        if (flit[c_MSB-1 -: FLIT_TYPE_W] == TAIL_FLIT) dn_active <= 1'b0;
      end
    end else if (ack) begin
      sb_store(flit);
      dn_active <= 1'b1;
    end
  end

  task automatic wait_sent(input string tag, input int budget);
    int k = 0;
    while (!pkt_sent && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(pkt_sent), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    FLIT_t h, b, t, msb_mask;
    logic [5:0] req_pat;
    msb_mask = '0;
    msb_mask[c_MSB] = 1'b1;

    reset = 1'b1; sw_valid = 1'b0; sw_flit = '0; ack = 1'b0;
    tick(2);
    check("rst_flit", 32'(flit), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(sw_ready), 32'd1);

    // Back-to-back H,B,T; ack two cycles after req (head pushed with MSB clear)
    h = make_flit(HEAD_FLIT, 13'h0A1);
    b = make_flit(BODY_FLIT, 13'h0B2);
    t = make_flit(TAIL_FLIT, 13'h0C3);
    sw_flit = h & ~msb_mask; sw_valid = 1'b1; sb_q.push_back(h);
    tick();
    sw_flit = b; sb_q.push_back(b);
    tick();
    check("t1_req", 32'(req), 32'd1);
    check("t1_head", 32'(flit), 32'(h));
    sw_flit = t; sb_q.push_back(t);
    tick();
    sw_valid = 1'b0;
    check("t1_req_hold", 32'(req), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_req_drop", 32'(req), 32'd0);
    check("t1_body", 32'(flit), 32'(b));
    tick();
    check("t1_tail", 32'(flit), 32'(t));
    tick();
    check("t1_sent", 32'(pkt_sent), 32'd1);
    check("t1_done_msb", 32'(flit[c_MSB]), 32'd0);
    tick();
    check("t1_sent_pulse", 32'(pkt_sent), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // Ack timeout: req 4 cycles, backoff 1 cycle, late ack in backoff
    h = make_flit(HEAD_FLIT, 13'h111);
    b = make_flit(BODY_FLIT, 13'h122);
    t = make_flit(TAIL_FLIT, 13'h133);
    sw_flit = h; sw_valid = 1'b1; sb_q.push_back(h);
    tick();
    sw_flit = b; sb_q.push_back(b);
    tick();
    req_pat = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      check("t2_req_pattern", 32'(req), 32'(req_pat[i]));
      if (i == 0) begin sw_flit = t; sb_q.push_back(t); end
      if (i == 1) sw_valid = 1'b0;
      tick();
    end
    tick(3);
    check("t2_backoff_req", 32'(req), 32'd0);
    check("t2_backoff_busy", 32'(busy), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_late_ack_body", 32'(flit), 32'(b));
    check("t2_req_low", 32'(req), 32'd0);
    tick();
    check("t2_tail", 32'(flit), 32'(t));
    tick();
    check("t2_sent", 32'(pkt_sent), 32'd1);
    tick();

    // Head alone, ack, then body and tail arrive late -> two bubbles
    h = make_flit(HEAD_FLIT, 13'h201);
    b = make_flit(BODY_FLIT, 13'h202);
    t = make_flit(TAIL_FLIT, 13'h203);
    sw_flit = h; sw_valid = 1'b1; sb_q.push_back(h);
    tick();
    sw_valid = 1'b0;
    tick();
    check("t3_req", 32'(req), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t3_bubble1", 32'(flit[c_MSB]), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    sw_flit = b; sw_valid = 1'b1; sb_q.push_back(b);
    tick();
    check("t3_bubble2", 32'(flit[c_MSB]), 32'd0);
    sw_flit = t; sb_q.push_back(t);
    tick();
    sw_valid = 1'b0;
    check("t3_body", 32'(flit), 32'(b));
    tick();
    check("t3_tail", 32'(flit), 32'(t));
    tick();
    check("t3_sent", 32'(pkt_sent), 32'd1);
    tick();

    // Stray body flit while idle
    sw_flit = make_flit(BODY_FLIT, 13'h0EE); sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    tick();
    check("t4_err", 32'(err), 32'd1);
    check("t4_no_req", 32'(req), 32'd0);
    tick();
    check("t4_err_pulse", 32'(err), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_ready", 32'(sw_ready), 32'd1);

    // Six flits against a stalled link: FIFO fills, then drains after ack
    fork
      begin
        logic acc;
        for (int i = 0; i < 6; i++) begin
          if (i == 0)      sw_flit = make_flit(HEAD_FLIT, 13'(12'h300 + i));
          else if (i == 5) sw_flit = make_flit(TAIL_FLIT, 13'(12'h300 + i));
          else             sw_flit = make_flit(BODY_FLIT, 13'(12'h300 + i));
          sw_valid = 1'b1;
          sb_q.push_back(sw_flit);
          for (int k = 0; k < 60; k++) begin
            acc = sw_ready;
            tick();
            if (acc) break;
          end
        end
        sw_valid = 1'b0;
      end
      begin
        tick(8);
        check("t5_full", 32'(sw_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        wait_sent("t5_sent", 40);
        check("t5_ready_back", 32'(sw_ready), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);
      end
    join
    tick();

    // Reset during SEND truncates the packet immediately
    h = make_flit(HEAD_FLIT, 13'h401);
    b = make_flit(BODY_FLIT, 13'h402);
    sw_flit = h; sw_valid = 1'b1; sb_q.push_back(h);
    tick();
    sw_flit = b;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(b);
      tick();
    end
    sw_valid = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t6_send_flit", 32'(flit), 32'(b));
    #2 reset = 1'b1;
    #1;
    check("t6_rst_req", 32'(req), 32'd0);
    check("t6_rst_flit", 32'(flit), 32'd0);
    check("t6_rst_ready", 32'(sw_ready), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    tick();
    reset = 1'b0;
    tick();
    check("t6_post_idle", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_unit.md
# output_unit

Transmit side of a router port. Buffers flits arriving from the switch stage and delivers each packet to the downstream router's input unit over the req/ack link. The downstream side answers a request with a one-cycle transmit ack and then stores every flit whose valid bit (MSB) is 1 until it sees the tail. This block requests the link per packet, streams head-to-tail with optional bubbles, and returns to idle.

## Interface
Parameters:
- FLIT_SIZE, router_pkg::FLIT_SIZE, flit width in bits; bit FLIT_SIZE-1 is the valid bit.
- DEPTH_BITS, 2, log2 of the local FIFO depth (default depth 4).
- ACK_TIMEOUT, 16, number of REQ cycles without ack before a one-cycle backoff; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_sw_flit  in  FLIT_SIZE  flit from the switch stage.
- i_sw_valid  in  1  i_sw_flit is valid.
- o_sw_ready  out  1  FIFO can accept; a push occurs when i_sw_valid && o_sw_ready.
- o_flit  out  FLIT_SIZE  registered flit to downstream; MSB=1 marks a flit to be stored.
- o_downstream_req  out  1  link request to the downstream input unit.
- i_transmit_ack  in  1  one-cycle grant from downstream.
- o_port_busy  out  1  high in every state except IDLE.
- o_pkt_sent  out  1  one-cycle pulse after the tail has been driven.
- o_err  out  1  one-cycle pulse on a protocol error (see Operation).

## Operation
- FIFO behaviour: pushes come from the switch; pops are controlled by the FSM. A push and a pop in the same cycle are both honoured. A push into an empty FIFO is visible at the front on the next cycle (no bypass).
- FSM states: IDLE, REQ, BACKOFF, SEND, DONE.
- IDLE:
  - FIFO front is HEAD_FLIT: pop it into o_flit with MSB forced to 1, set o_downstream_req, go to REQ.
  - FIFO front is a non-head flit: pop it, discard it, pulse o_err, stay in IDLE.
- REQ:
  - Hold o_flit and o_downstream_req; the cycle counter increments.
  - i_transmit_ack=1: the head counts as transferred at this edge. Clear req, go to SEND, and load the next flit (same rule as SEND).
  - ACK_TIMEOUT≠0 and counter = ACK_TIMEOUT-1 with no ack: clear req, clear the counter, go to BACKOFF.
- BACKOFF:
  - One cycle with req=0 and o_flit held, then return to REQ with req=1.
  - i_transmit_ack=1 sampled here (a late grant) is treated exactly as an ack in REQ.
- SEND, each cycle:
  - FIFO non-empty: pop into o_flit with MSB=1.
  - FIFO empty: drive o_flit MSB=0 as a bubble, with other bits don't-care.
  - The popped flit is TAIL_FLIT: go to DONE.
  - The popped flit is HEAD_FLIT: still forwarded, and o_err pulses.
- DONE: o_flit MSB=0, o_pkt_sent pulses, go to IDLE.
- Width rule: the counter width is $clog2(ACK_TIMEOUT+1) and the counter saturates.

## Timing
- Reset values:
  - o_flit=0, o_downstream_req=0, o_port_busy=0, o_pkt_sent=0, o_err=0.
  - FIFO empty, so o_sw_ready=1; state IDLE; counter 0.
- Reset asserted mid-packet clears the FIFO and drops req asynchronously; the packet is truncated. Downstream recovery is out of scope.
- Latency: a head pushed at edge N into an empty, idle unit gives REQ with o_downstream_req=1 and o_flit=head after edge N+1.
- Ack sampled at edge E:
  - Downstream stores the head at E.
  - o_flit carries the next flit (or a bubble) after E, and req is low after E.
- Throughput: one flit per cycle in SEND when the FIFO is fed continuously. An n-flit packet occupies the link for n cycles plus the ack wait.
- o_sw_ready is combinational (!full). When the FIFO is full, a pop in that cycle does not raise ready until the next cycle.
- Back-to-back packets: at least one DONE cycle plus one IDLE cycle separate a tail from the next req.

## Structure
- router_pkg holds:
  - FLIT_SIZE, the flit type enum (HEAD_FLIT, BODY_FLIT, TAIL_FLIT) and its bit position.
  - FLIT_t.
  - The state enum OU_STATE_t.
- One sub-module, ou_fifo: synchronous FIFO parameterised by width and depth bits, with active-high async reset, full/empty flags and registered storage.
- The FSM, the counter and the o_flit register live in output_unit.

## Test plan
- 3-flit packet H,B,T pushed back-to-back; ack returned 2 cycles after req -> req high 2 cycles, then o_flit = B then T with MSB=1, then o_pkt_sent=1 for one cycle.
- ACK_TIMEOUT=4, no ack -> req high 4 cycles, low 1 cycle, high again. Ack delivered in the BACKOFF cycle -> SEND entered, and B driven on the next cycle.
- Push only H, ack arrives, push B 3 cycles later, then T -> 2 bubble cycles with MSB=0, then B, then T; o_pkt_sent after T.
- BODY flit pushed while IDLE -> popped, o_err pulses once, no req.
- 6 flits pushed with the link stalled (no ack) -> o_sw_ready=0 once 4 flits are queued. After ack, everything drains and ready returns to 1.
- Reset asserted during SEND -> o_downstream_req=0 and o_flit=0 immediately, o_sw_ready=1, state IDLE.
